fpu_add_scheduler: RTL and testbench
====================================

Name: fpu_add_scheduler

Overview:
- Shares one fixed-latency FP add/sub datapath (exponent compare -> mantissa alignment -> add -> normalize) between NUM_REQ requesters.
- Arbitrates requests, registers the selected operands into the datapath and tracks requester IDs in a tag pipeline.
- Routes each returning result to the requester that issued it.
- Sits between the core issue ports and the shared adder pipeline.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- DATA_W, 32, operand/result width (IEEE-754 single)
- LATENCY, 4, datapath cycles from dp_valid to dp_result valid (>=1)

Ports:
- clk  in  1  clock
- arst_n  in  1  asynchronous reset, active-low
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester grant/accept
- req_op  in  NUM_REQ  per-requester op: 0=add, 1=sub
- req_a  in  NUM_REQ*DATA_W  packed operand A; requester i at bits [i*DATA_W +: DATA_W]
- req_b  in  NUM_REQ*DATA_W  packed operand B, same packing
- flush  in  1  synchronous pipeline kill
- dp_valid  out  1  operands valid to datapath
- dp_op  out  1  op to datapath
- dp_a  out  DATA_W  operand A to datapath
- dp_b  out  DATA_W  operand B to datapath
- dp_result  in  DATA_W  datapath result, valid exactly LATENCY cycles after dp_valid
- rsp_valid  out  NUM_REQ  one-hot result valid
- rsp_data  out  DATA_W  result, shared by all requesters
- inflight  out  $clog2(LATENCY+3)  accepted but not yet responded ops
- busy  out  1  inflight != 0

Behaviour:
- Reset values: dp_valid=0, dp_op=0, dp_a=0, dp_b=0, rsp_valid=0, rsp_data=0, inflight=0. RR pointer reset so requester 0 has top priority. All tag-pipeline valids cleared.
- Arbitration:
  - Combinational round-robin over req_valid, starting at (last_grant+1) mod NUM_REQ.
  - req_ready is one-hot on the winner; all zero when no request is valid or flush=1.
  - req_ready may depend on req_valid; req_valid must not depend on req_ready.
- Handshake: req_valid[i] & req_ready[i] sampled at a rising edge. At most one accept per cycle. The pointer updates to i on accept only.
- Issue, edge E0 = accept edge:
  - After E0: dp_valid=1, and dp_a/dp_b/dp_op are the accepted requester's values.
  - dp_valid=0 in cycles with no accept.
- Tag pipeline: LATENCY+1 registered stages of {valid, id}, with a stage aligned to dp_valid. The last stage coincides with dp_result being valid.
- Response:
  - Registered: rsp_valid[id]=1 and rsp_data=dp_result one cycle after the tag reaches its last stage.
  - Total latency: accept edge E0 -> rsp_valid high in cycle E0+LATENCY+2, for exactly one cycle.
  - No response backpressure; requesters must accept. rsp_data holds its last value when rsp_valid=0.
- Throughput: one op per cycle sustained. Order within a requester is preserved. Responses come back in global issue order.
- inflight:
  - +1 on accept, -1 on rsp_valid pulse; simultaneous accept and response leaves it unchanged.
  - Never exceeds LATENCY+2, so no overflow.
- flush = 1 at edge:
  - No accept that cycle.
  - All tag valids, dp_valid, rsp_valid and inflight go to 0 after the edge.
  - Results for killed ops are never signalled.
  - RR pointer is kept.
- Reset mid-operation: in-flight ops are discarded silently; outputs go to reset values immediately (asynchronous).
- Single requester asserting continuously: accepted every cycle (RR does not starve a lone requester).

Optional Feature:
- FPU_SCHED_FIXED_PRIO_EN defined: arbitration is fixed priority, lowest index wins, and the RR pointer logic is removed.
- Undefined (default): round-robin as above.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, LATENCY=4:
  - Stimulus: assert arst_n low mid-stream with 3 ops in flight.
  - Required: all outputs 0 immediately, no rsp_valid after release, inflight=0.
- Single op:
  - Stimulus: req 0, A=0x3F800000, B=0x40000000, add; accepted at edge 0; datapath model returns 0x40400000.
  - Required: dp_valid high in cycle 1, rsp_valid=2'b01 and rsp_data=0x40400000 in cycle 6, inflight 1 through cycle 6 then 0.
- Contention:
  - Stimulus: req 0 and req 1 both valid continuously for 6 cycles.
  - Required: grants alternate 0,1,0,1,0,1; responses return one per cycle in the same order.
  - With FPU_SCHED_FIXED_PRIO_EN: all 6 grants go to 0.
- Back-to-back single requester:
  - Stimulus: req 1 valid for 5 consecutive cycles.
  - Required: 5 accepts; rsp_valid=2'b10 for 5 consecutive cycles; inflight peaks at 5 and never exceeds LATENCY+2=6.
- Flush:
  - Stimulus: issue 3 ops, assert flush on the cycle after the third accept, with req 0 valid.
  - Required: req_ready=0 during flush; no rsp_valid for the 3 ops; inflight=0 after the edge; the next request is accepted normally and answered at E0+6.
- Simultaneous accept and response:
  - Stimulus: a steady stream where accepts coincide with responses.
  - Required: inflight is constant during steady state; busy stays high until the final response, then goes low the next cycle.

Source files
------------

// File: rtl/fpu_add_scheduler.sv
// Arbitrates NUM_REQ requesters onto one shared fixed-latency FP add/sub datapath and routes each result back to its issuer.
// Build option: define FPU_SCHED_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module fpu_add_scheduler #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 4
) (
    input  logic                          clk,
    input  logic                          arst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_op,
    input  logic [NUM_REQ*DATA_W-1:0]     req_a,
    input  logic [NUM_REQ*DATA_W-1:0]     req_b,
    input  logic                          flush,
    output logic                          dp_valid,
    output logic                          dp_op,
    output logic [DATA_W-1:0]             dp_a,
    output logic [DATA_W-1:0]             dp_b,
    input  logic [DATA_W-1:0]             dp_result,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_W-1:0]             rsp_data,
    output logic [$clog2(LATENCY+3)-1:0]  inflight,
    output logic                          busy
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(LATENCY+3);

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               grant_any;
    logic [ID_W-1:0]    idx;
    logic               accept;

`ifdef FPU_SCHED_FIXED_PRIO_EN
    always_comb begin
        // NOTE: combinational blocks use blocking '=' and assign every output a default first, so no latch is inferred.
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        idx       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = ID_W'(i);
            if (!grant_any && req_valid[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = idx;
                grant_any  = 1'b1;
            end
        end
    end
`else
    logic [ID_W-1:0] last_grant;

    // Search starts one past the last winner, so a lone requester still wins every cycle.
    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        idx       = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = ID_W'((int'(last_grant) + i) % NUM_REQ);
            if (!grant_any && req_valid[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = idx;
                grant_any  = 1'b1;
            end
        end
    end

    // Pointer survives flush; reset value gives requester 0 top priority.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)
            last_grant <= ID_W'(NUM_REQ - 1);
        else if (accept)
            last_grant <= grant_id;
    end
`endif

    assign req_ready = flush ? '0 : grant;
    assign accept    = grant_any & ~flush;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            dp_valid <= 1'b0;
            dp_op    <= 1'b0;
            dp_a     <= '0;
            dp_b     <= '0;
        end else begin
            dp_valid <= accept;
            if (accept) begin
                dp_op <= req_op[grant_id];
                dp_a  <= req_a[grant_id*DATA_W +: DATA_W];
                dp_b  <= req_b[grant_id*DATA_W +: DATA_W];
            end
        end
    end

    // Stage 0 lines up with dp_valid; stage LATENCY lines up with dp_result.
    logic [LATENCY:0] tag_valid;
    logic [ID_W-1:0]  tag_id [LATENCY+1];

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)
            tag_valid <= '0;
        else if (flush)
            tag_valid <= '0;
        else
            tag_valid <= {tag_valid[LATENCY-1:0], accept};
    end

    // NOTE: the id shift register has no reset; tag_valid qualifies every stage, so stale ids are never used.
    always_ff @(posedge clk) begin
        tag_id[0] <= grant_id;
        for (int k = 1; k <= LATENCY; k++)
            tag_id[k] <= tag_id[k-1];
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else if (flush) begin
            rsp_valid <= '0;
        end else if (tag_valid[LATENCY]) begin
            rsp_valid <= NUM_REQ'(1) << tag_id[LATENCY];
            rsp_data  <= dp_result;
        end else begin
            rsp_valid <= '0;
        end
    end

    logic rsp_done;
    assign rsp_done = |rsp_valid;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)
            inflight <= '0;
        else if (flush)
            inflight <= '0;
        else if (accept && !rsp_done)
            inflight <= inflight + CNT_W'(1);
        else if (!accept && rsp_done)
            inflight <= inflight - CNT_W'(1);
    end

    assign busy = (inflight != '0);

endmodule

// File: tb/tb_fpu_add_scheduler.sv
// Directed bench for fpu_add_scheduler (NUM_REQ=2, LATENCY=4) with a fixed-latency datapath model.
module tb_fpu_add_scheduler;

    localparam int NUM_REQ = 2;
    localparam int DATA_W  = 32;
    localparam int LATENCY = 4;

    logic                      clk = 1'b0;
    logic                      arst_n = 1'b0;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_op = '0;
    logic [NUM_REQ*DATA_W-1:0] req_a = '0;
    logic [NUM_REQ*DATA_W-1:0] req_b = '0;
    logic                      flush = 1'b0;
    logic                      dp_valid;
    logic                      dp_op;
    logic [DATA_W-1:0]         dp_a;
    logic [DATA_W-1:0]         dp_b;
    logic [DATA_W-1:0]         dp_result;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic [2:0]                inflight;
    logic                      busy;

    int passed = 0;
    int total  = 0;

    fpu_add_scheduler #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .LATENCY(LATENCY)) dut (
        .clk(clk), .arst_n(arst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .flush(flush),
        .dp_valid(dp_valid), .dp_op(dp_op), .dp_a(dp_a), .dp_b(dp_b),
        .dp_result(dp_result),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .inflight(inflight), .busy(busy)
    );

    always #5 clk = ~clk;

    // Known float vectors return the true IEEE result; anything else returns an integer stand-in.
    function automatic logic [31:0] fp_model(input logic [31:0] a, input logic [31:0] b, input logic op);
        if (a == 32'h3F800000 && b == 32'h40000000 && !op) return 32'h40400000;
        if (a == 32'h40000000 && b == 32'h3F800000 && op)  return 32'h3F800000;
        return op ? a - b : a + b;
    endfunction

    logic [31:0] dp_pipe [LATENCY];
    always_ff @(posedge clk) begin
        dp_pipe[0] <= dp_valid ? fp_model(dp_a, dp_b, dp_op) : 32'h0;
        for (int i = 1; i < LATENCY; i++)
            dp_pipe[i] <= dp_pipe[i-1];
    end
    assign dp_result = dp_pipe[LATENCY-1];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] op,
                         input logic [31:0] a0, input logic [31:0] b0,
                         input logic [31:0] a1, input logic [31:0] b1);
        req_valid = v;
        req_op    = op;
        req_a     = {a1, a0};
        req_b     = {b1, b0};
    endtask

    task automatic test_reset();
        logic seen_rsp;
        logic bad_cnt;
        #2;
        total++; if (dp_valid !== 1'b0) $display("FAIL rst_dp_valid got=%b exp=0", dp_valid); else passed++;
        total++; if (rsp_valid !== 2'b00) $display("FAIL rst_rsp_valid got=%b exp=00", rsp_valid); else passed++;
        total++; if (inflight !== 3'd0) $display("FAIL rst_inflight got=%0d exp=0", inflight); else passed++;
        @(posedge clk); #1;
        arst_n = 1'b1;
        for (int t = 0; t < 3; t++) begin
            drive(2'b01, 2'b00, 32'h100 + t, 32'h1, 32'h0, 32'h0);
            step();
        end
        drive(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        total++; if (inflight !== 3'd3) $display("FAIL mid_inflight got=%0d exp=3", inflight); else passed++;
        total++; if (dp_valid !== 1'b1) $display("FAIL mid_dp_valid got=%b exp=1", dp_valid); else passed++;
        arst_n = 1'b0;
        #1;
        total++; if ({dp_valid, dp_op, dp_a, dp_b} !== 66'h0) $display("FAIL async_dp got=%b/%b/%h/%h exp=0", dp_valid, dp_op, dp_a, dp_b); else passed++;
        total++; if ({rsp_valid, rsp_data} !== 34'h0) $display("FAIL async_rsp got=%b/%h exp=0", rsp_valid, rsp_data); else passed++;
        total++; if ({inflight, busy} !== 4'h0) $display("FAIL async_inflight got=%0d/%b exp=0", inflight, busy); else passed++;
        step();
        step();
        arst_n = 1'b1;
        seen_rsp = 1'b0;
        bad_cnt  = 1'b0;
        for (int t = 0; t < 10; t++) begin
            step();
            if (rsp_valid !== 2'b00) seen_rsp = 1'b1;
            if (inflight !== 3'd0) bad_cnt = 1'b1;
        end
        total++; if (seen_rsp !== 1'b0) $display("FAIL post_rst_rsp got=%b exp=0", seen_rsp); else passed++;
        total++; if (bad_cnt !== 1'b0) $display("FAIL post_rst_inflight got=%b exp=0", bad_cnt); else passed++;
    endtask

    task automatic test_contention();
        logic [1:0]  exp_ready [6];
        logic [31:0] exp_data [6];
        int g;
        for (int t = 0; t < 14; t++) begin
            if (t < 6) drive(2'b11, 2'b00, 32'h1000 + t, 32'h1, 32'h2000 + t, 32'h1);
            else       drive(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
            #1;
            if (t < 6) begin
`ifdef FPU_SCHED_FIXED_PRIO_EN
                g = 0;
`else
                g = t % 2;
`endif
                exp_ready[t] = (g == 0) ? 2'b01 : 2'b10;
                exp_data[t]  = ((g == 0) ? 32'h1000 : 32'h2000) + t + 1;
                total++; if (req_ready !== exp_ready[t]) $display("FAIL cont_grant%0d got=%b exp=%b", t, req_ready, exp_ready[t]); else passed++;
            end
            if (t >= 6 && t < 12) begin
                total++; if (rsp_valid !== exp_ready[t-6]) $display("FAIL cont_rsp_valid%0d got=%b exp=%b", t-6, rsp_valid, exp_ready[t-6]); else passed++;
                total++; if (rsp_data !== exp_data[t-6]) $display("FAIL cont_rsp_data%0d got=%h exp=%h", t-6, rsp_data, exp_data[t-6]); else passed++;
            end
            if (t == 12) begin
                total++; if (rsp_valid !== 2'b00) $display("FAIL cont_rsp_end got=%b exp=00", rsp_valid); else passed++;
            end
            step();
        end
    endtask

    task automatic test_single_op();
        logic early_rsp;
        logic cnt_bad;
        early_rsp = 1'b0;
        cnt_bad   = 1'b0;
        for (int t = 0; t < 8; t++) begin
            if (t == 0) drive(2'b01, 2'b00, 32'h3F800000, 32'h40000000, 32'h0, 32'h0);
            else        drive(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
            #1;
            if (t == 0) begin
                total++; if (req_ready !== 2'b01) $display("FAIL single_ready got=%b exp=01", req_ready); else passed++;
            end
            if (t == 1) begin
                total++; if (dp_valid !== 1'b1) $display("FAIL single_dp_valid got=%b exp=1", dp_valid); else passed++;
                total++; if ({dp_op, dp_a, dp_b} !== {1'b0, 32'h3F800000, 32'h40000000}) $display("FAIL single_dp_ops got=%b/%h/%h exp=0/3f800000/40000000", dp_op, dp_a, dp_b); else passed++;
            end
            if (t == 2) begin
                total++; if (dp_valid !== 1'b0) $display("FAIL single_dp_idle got=%b exp=0", dp_valid); else passed++;
            end
            if (t >= 1 && t <= 6 && inflight !== 3'd1) cnt_bad = 1'b1;
            if (t >= 1 && t <= 5 && rsp_valid !== 2'b00) early_rsp = 1'b1;
            if (t == 6) begin
                total++; if (rsp_valid !== 2'b01) $display("FAIL single_rsp_valid got=%b exp=01", rsp_valid); else passed++;
                total++; if (rsp_data !== 32'h40400000) $display("FAIL single_rsp_data got=%h exp=40400000", rsp_data); else passed++;
            end
            if (t == 7) begin
                total++; if (rsp_valid !== 2'b00) $display("FAIL single_rsp_pulse got=%b exp=00", rsp_valid); else passed++;
                total++; if ({inflight, busy} !== 4'h0) $display("FAIL single_drain got=%0d/%b exp=0/0", inflight, busy); else passed++;
                total++; if (rsp_data !== 32'h40400000) $display("FAIL single_rsp_hold got=%h exp=40400000", rsp_data); else passed++;
            end
            step();
        end
        total++; if (cnt_bad !== 1'b0) $display("FAIL single_inflight got=%b exp=0", cnt_bad); else passed++;
        total++; if (early_rsp !== 1'b0) $display("FAIL single_early_rsp got=%b exp=0", early_rsp); else passed++;
    endtask

    task automatic test_back_to_back();
        int peak;
        peak = 0;
        for (int t = 0; t < 13; t++) begin
            if (t < 5) drive(2'b10, 2'b00, 32'h0, 32'h0, 32'h500 + t, 32'h7);
            else       drive(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
            #1;
            if (int'(inflight) > peak) peak = int'(inflight);
            if (t < 5) begin
                total++; if (req_ready !== 2'b10) $display("FAIL b2b_ready%0d got=%b exp=10", t, req_ready); else passed++;
            end
            if (t >= 6 && t < 11) begin
                total++; if (rsp_valid !== 2'b10) $display("FAIL b2b_rsp_valid%0d got=%b exp=10", t-6, rsp_valid); else passed++;
                total++; if (rsp_data !== 32'h507 + (t - 6)) $display("FAIL b2b_rsp_data%0d got=%h exp=%h", t-6, rsp_data, 32'h507 + (t - 6)); else passed++;
            end
            if (t == 11) begin
                total++; if (rsp_valid !== 2'b00) $display("FAIL b2b_rsp_end got=%b exp=00", rsp_valid); else passed++;
            end
            step();
        end
        total++; if (peak != 5) $display("FAIL b2b_peak got=%0d exp=5", peak); else passed++;
    endtask

    task automatic test_flush();
        logic stray;
        stray = 1'b0;
        for (int t = 0; t < 13; t++) begin
            flush = (t == 3);
            if (t < 3)       drive(2'b01, 2'b00, 32'h700 + t, 32'h1, 32'h0, 32'h0);
            else if (t < 5)  drive(2'b01, 2'b01, 32'h40000000, 32'h3F800000, 32'h0, 32'h0);
            else             drive(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
            #1;
            if (t == 3) begin
                total++; if (req_ready !== 2'b00) $display("FAIL flush_ready got=%b exp=00", req_ready); else passed++;
                total++; if (inflight !== 3'd3) $display("FAIL flush_pre_inflight got=%0d exp=3", inflight); else passed++;
            end
            if (t == 4) begin
                total++; if ({inflight, dp_valid, rsp_valid} !== 6'h0) $display("FAIL flush_clear got=%0d/%b/%b exp=0/0/00", inflight, dp_valid, rsp_valid); else passed++;
                total++; if (req_ready !== 2'b01) $display("FAIL flush_next_ready got=%b exp=01", req_ready); else passed++;
            end
            if (t >= 4 && t <= 12 && t != 10 && rsp_valid !== 2'b00) stray = 1'b1;
            if (t == 10) begin
                total++; if (rsp_valid !== 2'b01) $display("FAIL flush_next_rsp got=%b exp=01", rsp_valid); else passed++;
                total++; if (rsp_data !== 32'h3F800000) $display("FAIL flush_next_data got=%h exp=3f800000", rsp_data); else passed++;
            end
            if (t == 4) drive(2'b01, 2'b01, 32'h40000000, 32'h3F800000, 32'h0, 32'h0);
            step();
            if (t == 4) drive(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        end
        total++; if (stray !== 1'b0) $display("FAIL flush_killed_rsp got=%b exp=0", stray); else passed++;
    endtask

    task automatic test_steady();
        logic cnt_var;
        cnt_var = 1'b0;
        for (int t = 0; t < 19; t++) begin
            if (t < 12) drive(2'b01, 2'b00, 32'h3000 + t, 32'h10, 32'h0, 32'h0);
            else        drive(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
            #1;
            if (t >= 6 && t <= 12 && inflight !== 3'd6) cnt_var = 1'b1;
            if (t >= 6 && t <= 17) begin
                total++; if ({rsp_valid, rsp_data} !== {2'b01, 32'h3010 + (t - 6)}) $display("FAIL steady_rsp%0d got=%b/%h exp=01/%h", t-6, rsp_valid, rsp_data, 32'h3010 + (t - 6)); else passed++;
            end
            if (t == 17) begin
                total++; if (busy !== 1'b1) $display("FAIL steady_busy_last got=%b exp=1", busy); else passed++;
            end
            if (t == 18) begin
                total++; if ({busy, inflight} !== 4'h0) $display("FAIL steady_idle got=%b/%0d exp=0/0", busy, inflight); else passed++;
            end
            step();
        end
        total++; if (cnt_var !== 1'b0) $display("FAIL steady_inflight_const got=%b exp=0", cnt_var); else passed++;
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single_op();
        test_back_to_back();
        test_flush();
        test_steady();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", passed, total);
        $fatal(1, "watchdog");
    end

endmodule
